// File: rtl/audio_playback_sequencer.sv
// Streams samples from sample memory to the DAC serializer over a valid/ready handshake.
// Optional SEQ_VOLUME_EN adds vol_shift, an arithmetic right-shift applied at capture.
module audio_playback_sequencer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 48000,
    parameter int unsigned UNDERRUN_W = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic [15:0]           mem_rdata,
`ifdef SEQ_VOLUME_EN
    input  logic [2:0]            vol_shift,
`endif
    output logic [15:0]           sample,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam logic [ADDR_W-1:0]     LAST_ADDR    = ADDR_W'(DEPTH - 1);
    localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [15:0]           sample_q, sample_d;
    logic                  done_q, done_d;
    logic [UNDERRUN_W-1:0] ucnt_q, ucnt_d;
    logic [15:0]           captured;

`ifdef SEQ_VOLUME_EN
    assign captured = $signed(mem_rdata) >>> vol_shift;
`else
    assign captured = mem_rdata;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        done_d   = 1'b0;
        ucnt_d   = ucnt_q;

        // sample_valid is always low in FETCH/WAIT, so a request there is an underrun
        if (sample_ready && (state_q == FETCH || state_q == WAIT) && ucnt_q != UNDERRUN_MAX) begin
            ucnt_d = ucnt_q + 1'b1;
        end

        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end
                end
                FETCH: state_d = WAIT;
                WAIT: begin
                    sample_d = captured;
                    state_d  = HOLD;
                end
                HOLD: begin
                    if (sample_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            addr_d = '0;
                            if (loop_en) begin
                                state_d = FETCH;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sample_q <= '0;
            done_q   <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            done_q   <= done_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_rd       = (state_q == FETCH);
    assign sample       = sample_q;
    assign sample_valid = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Bench for audio_playback_sequencer: directed vector table, hand sequences, and random
// stimulus against a cycle-count reference model (supports SEQ_VOLUME_EN when defined).
module tb_audio_playback_sequencer;

    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 4;
    localparam int UNDERRUN_W = 2;
    localparam int UMAX       = (1 << UNDERRUN_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  loop_en = 1'b0;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_rd;
    logic [15:0]           mem_rdata = 16'h0;
    logic [2:0]            vol_shift = 3'd0;
    logic [15:0]           sample;
    logic                  sample_valid;
    logic                  sample_ready = 1'b0;
    logic                  busy;
    logic                  done;
    logic [UNDERRUN_W-1:0] underrun_cnt;

    logic [15:0] mem [16];

    audio_playback_sequencer #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .UNDERRUN_W (UNDERRUN_W)
    ) dut (
        .CLOCK_50     (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
`ifdef SEQ_VOLUME_EN
        .vol_shift    (vol_shift),
`endif
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // One-cycle read latency; junk on the bus whenever no read was issued
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 16'($urandom);
    end

    int total = 0;
    int passed = 0;
    int done_cnt = 0;
    logic [15:0] rx[$];

    // Reference model: "cycles until valid" countdown (2 = read issued, 0 = presenting)
    bit          m_active;
    int          m_addr, m_wait, m_under;
    logic [15:0] m_sample;
    bit          m_done;

    function automatic logic [15:0] scaled(input logic [15:0] w);
`ifdef SEQ_VOLUME_EN
        logic signed [15:0] s;
        s = w;
        return s >>> vol_shift;
`else
        return w;
`endif
    endfunction

    task automatic model_step();
        if (!reset_n) begin
            m_active = 0; m_addr = 0; m_wait = 0; m_sample = 16'h0; m_done = 0; m_under = 0;
            return;
        end
        m_done = 0;
        if (sample_ready && m_active && m_wait > 0 && m_under < UMAX) m_under++;
        if (m_active && stop) begin
            m_active = 0; m_addr = 0;
        end else if (!m_active) begin
            if (start && !stop) begin m_active = 1; m_addr = 0; m_wait = 2; end
        end else if (m_wait == 2) begin
            m_wait = 1;
        end else if (m_wait == 1) begin
            m_sample = scaled(mem[m_addr]); m_wait = 0;
        end else if (sample_ready) begin
            if (m_addr == DEPTH - 1) begin
                m_addr = 0;
                if (loop_en) m_wait = 2;
                else begin m_active = 0; m_done = 1; end
            end else begin
                m_addr++; m_wait = 2;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        if (sample_valid === 1'b1 && sample_ready === 1'b1) rx.push_back(sample);
        model_step();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_rd", 32'(mem_rd), 32'(m_active && m_wait == 2));
        chk("sample", 32'(sample), 32'(m_sample));
        chk("sample_valid", 32'(sample_valid), 32'(m_active && m_wait == 0));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_done));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
    endtask

    task automatic do_reset();
        reset_n = 0; start = 0; stop = 0; sample_ready = 0;
        step();
        reset_n = 1;
    endtask

    typedef struct {
        bit          rst_n, st, sp, lp, rdy;
        bit          rd;
        int          addr;
        bit          valid;
        logic [15:0] smp;
        bit          bsy, dn;
        int          ucnt;
    } vec_t;

    function automatic vec_t mk(bit rst_n, bit st, bit sp, bit lp, bit rdy, bit rd, int addr,
                                bit valid, logic [15:0] smp, bit bsy, bit dn, int ucnt);
        vec_t v;
        v.rst_n = rst_n; v.st = st; v.sp = sp; v.lp = lp; v.rdy = rdy;
        v.rd = rd; v.addr = addr; v.valid = valid; v.smp = smp; v.bsy = bsy; v.dn = dn;
        v.ucnt = ucnt;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234; mem[1] = 16'hBEEF; mem[2] = 16'h0055; mem[3] = 16'h8000;

        // Ready held high from start: one sample per 3 cycles, underrun saturates at 3
        vecs[0]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 1,  1, 0, 0, 16'h0000, 1, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 1,  0, 0, 0, 16'h0000, 1, 0, 1);
        vecs[3]  = mk(1, 0, 0, 0, 1,  0, 0, 1, 16'h1234, 1, 0, 2);
        vecs[4]  = mk(1, 0, 0, 0, 1,  1, 1, 0, 16'h1234, 1, 0, 2);
        vecs[5]  = mk(1, 0, 0, 0, 1,  0, 1, 0, 16'h1234, 1, 0, 3);
        vecs[6]  = mk(1, 0, 0, 0, 1,  0, 1, 1, 16'hBEEF, 1, 0, 3);
        vecs[7]  = mk(1, 0, 0, 0, 1,  1, 2, 0, 16'hBEEF, 1, 0, 3);
        vecs[8]  = mk(1, 0, 0, 0, 1,  0, 2, 0, 16'hBEEF, 1, 0, 3);
        vecs[9]  = mk(1, 0, 0, 0, 1,  0, 2, 1, 16'h0055, 1, 0, 3);
        vecs[10] = mk(1, 0, 0, 0, 1,  1, 3, 0, 16'h0055, 1, 0, 3);
        vecs[11] = mk(1, 0, 0, 0, 1,  0, 3, 0, 16'h0055, 1, 0, 3);
        vecs[12] = mk(1, 0, 0, 0, 1,  0, 3, 1, 16'h8000, 1, 0, 3);
        vecs[13] = mk(1, 0, 0, 0, 1,  0, 0, 0, 16'h8000, 0, 1, 3);
        vecs[14] = mk(1, 0, 0, 0, 1,  0, 0, 0, 16'h8000, 0, 0, 3);

        for (int i = 0; i < 15; i++) begin
            reset_n = vecs[i].rst_n; start = vecs[i].st; stop = vecs[i].sp;
            loop_en = vecs[i].lp; sample_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d.mem_rd", i), 32'(mem_rd), 32'(vecs[i].rd));
            chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d.valid", i), 32'(sample_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.sample", i), 32'(sample), 32'(vecs[i].smp));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("vec%0d.ucnt", i), 32'(underrun_cnt), 32'(vecs[i].ucnt));
        end

        // Looping: A B C D A B, then clear loop_en so the pass ends after the second D
        do_reset();
        rx.delete(); done_cnt = 0;
        loop_en = 1; start = 1; step(); start = 0;
        sample_ready = 1;
        for (int i = 0; i < 60 && rx.size() < 6; i++) step();
        chk("loop.no_done_while_looping", 32'(done_cnt), 32'd0);
        loop_en = 0;
        for (int i = 0; i < 60 && busy; i++) step();
        chk("loop.rx_count", 32'(rx.size()), 32'd8);
        for (int i = 0; i < 8 && i < rx.size(); i++)
            chk($sformatf("loop.rx%0d", i), 32'(rx[i]), 32'(mem[i % 4]));
        chk("loop.done_once", 32'(done_cnt), 32'd1);
        chk("loop.idle", 32'(busy), 32'd0);

        // stop during WAIT: read in flight discarded, no done pulse
        do_reset();
        done_cnt = 0; sample_ready = 0;
        start = 1; step(); start = 0;
        step();
        chk("stop.in_wait", 32'(dut.mem_rd == 0 && busy && !sample_valid), 32'd1);
        stop = 1; step(); stop = 0;
        chk("stop.busy", 32'(busy), 32'd0);
        chk("stop.valid", 32'(sample_valid), 32'd0);
        step(); step();
        chk("stop.no_done", 32'(done_cnt), 32'd0);

        // start+stop together in IDLE: nothing happens
        start = 1; stop = 1; step(); start = 0; stop = 0;
        chk("startstop.busy", 32'(busy), 32'd0);
        step();
        chk("startstop.busy_later", 32'(busy), 32'd0);

        // Reset while holding the last sample (16'h8000)
        vol_shift = 3'd3;
        start = 1; step(); start = 0;
        for (int i = 0; i < 40; i++) begin
            if (sample_valid && mem_addr == 3) break;
            sample_ready = sample_valid;
            step();
        end
        sample_ready = 0;
`ifdef SEQ_VOLUME_EN
        chk("hold.sample_last", 32'(sample), 32'h0000F000);
`else
        chk("hold.sample_last", 32'(sample), 32'h00008000);
`endif
        vol_shift = 3'd0;
        step();
        chk("hold.stable", 32'(sample_valid), 32'd1);
        reset_n = 0; step(); reset_n = 1;
        chk("rst.sample", 32'(sample), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset_n      = ($urandom_range(0, 99) != 0);
            start        = ($urandom_range(0, 9) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            loop_en      = ($urandom_range(0, 9) < 7);
            sample_ready = $urandom_range(0, 1) != 0;
            vol_shift    = 3'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
